// File: rtl/mopshub_sdo_pkg.sv
// Shared definitions for the MOPSHUB SDO path: FSM states, SDO command
// bytes, abort codes, object indices, COB-ID bases and 76-bit frame layout.
package mopshub_sdo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_ADC_WAIT = 2'd2,
    ST_SEND     = 2'd3
  } sdo_state_t;

  // SDO command bytes
  localparam logic [7:0] CMD_UPLOAD_REQ  = 8'h40;
  localparam logic [7:0] CMD_UPLOAD_RSP4 = 8'h43;
  localparam logic [7:0] CMD_UPLOAD_RSP2 = 8'h4B;
  localparam logic [7:0] CMD_DNLOAD_RSP  = 8'h60;
  localparam logic [7:0] CMD_ABORT       = 8'h80;
  localparam logic [7:0] CMD_DNLOAD_4    = 8'h23;
  localparam logic [7:0] CMD_DNLOAD_3    = 8'h27;
  localparam logic [7:0] CMD_DNLOAD_2    = 8'h2B;
  localparam logic [7:0] CMD_DNLOAD_1    = 8'h2F;

  // Abort codes
  localparam logic [31:0] ABORT_BAD_CMD   = 32'h0504_0001;
  localparam logic [31:0] ABORT_READ_ONLY = 32'h0601_0002;
  localparam logic [31:0] ABORT_NO_OBJECT = 32'h0602_0000;
  localparam logic [31:0] ABORT_NO_SUB    = 32'h0609_0011;
  localparam logic [31:0] ABORT_HW_ERROR  = 32'h0800_0000;

  // Object dictionary indices
  localparam logic [15:0] IDX_DEV_TYPE = 16'h1000;
  localparam logic [15:0] IDX_USER_REG = 16'h2200;
  localparam logic [15:0] IDX_ADC      = 16'h2400;

  // COB-ID bases
  localparam logic [10:0] COB_TX_BASE = 11'h580;
  localparam logic [10:0] COB_RX_BASE = 11'h600;

  // Frame field positions
  localparam int unsigned FRAME_W   = 76;
  localparam int unsigned COB_MSB   = 75;
  localparam int unsigned COB_LSB   = 65;
  localparam int unsigned RTR_BIT   = 64;
  localparam int unsigned CMD_MSB   = 63;
  localparam int unsigned CMD_LSB   = 56;
  localparam int unsigned IDXL_MSB  = 55;
  localparam int unsigned IDXL_LSB  = 48;
  localparam int unsigned IDXH_MSB  = 47;
  localparam int unsigned IDXH_LSB  = 40;
  localparam int unsigned SUB_MSB   = 39;
  localparam int unsigned SUB_LSB   = 32;
  localparam int unsigned DATA_MSB  = 31;
  localparam int unsigned DATA_LSB  = 0;

  // Payload bytes 4..7 carry a little-endian value with byte4 in the top lane
  function automatic logic [31:0] swap_bytes(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Bytes actually carried by an expedited download command
  function automatic logic [31:0] dnload_mask(input logic [7:0] cmd);
    case (cmd)
      CMD_DNLOAD_1: return 32'h0000_00FF;
      CMD_DNLOAD_2: return 32'h0000_FFFF;
      CMD_DNLOAD_3: return 32'h00FF_FFFF;
      default:      return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/sdo_frame_pack.sv
// Combinational packer of SDO response fields into the 76-bit CAN frame.
module sdo_frame_pack
  import mopshub_sdo_pkg::*;
(
  input  logic [10:0] cob,
  input  logic [7:0]  cmd,
  input  logic [15:0] idx,
  input  logic [7:0]  sub,
  input  logic [31:0] value,
  output logic [75:0] frame
);

  // Place each field; value is emitted little-endian in bytes 4..7
  always_comb begin
    frame                     = '0;
    frame[COB_MSB:COB_LSB]    = cob;
    frame[RTR_BIT]            = 1'b0;
    frame[CMD_MSB:CMD_LSB]    = cmd;
    frame[IDXL_MSB:IDXL_LSB]  = idx[7:0];
    frame[IDXH_MSB:IDXH_LSB]  = idx[15:8];
    frame[SUB_MSB:SUB_LSB]    = sub;
    frame[DATA_MSB:DATA_LSB]  = swap_bytes(value);
  end

endmodule

// File: rtl/mops_sdo_responder.sv
// Emulated MOPS CANopen SDO server: ADC uploads, device type, user register.
module mops_sdo_responder
  import mopshub_sdo_pkg::*;
#(
  parameter logic [6:0]  NODE_ID     = 7'h00,
  parameter int unsigned N_ADC       = 35,
  parameter logic [31:0] DEV_TYPE    = 32'h0000_0000,
  parameter logic [15:0] ADC_TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] rx_frame,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [75:0] tx_frame,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        adc_req,
  output logic [5:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  output logic [31:0] user_reg,
  output logic        busy
);

  localparam logic [10:0] RX_COB    = COB_RX_BASE + {4'h0, NODE_ID};
  localparam logic [10:0] TX_COB    = COB_TX_BASE + {4'h0, NODE_ID};
  localparam logic [7:0]  N_ADC_SUB = 8'(N_ADC);

  sdo_state_t  state, state_nxt;
  logic [7:0]  req_cmd;
  logic [15:0] req_idx;
  logic [7:0]  req_sub;
  logic [31:0] req_val;
  logic [15:0] tmo_cnt;
  logic        rx_match;
  logic        is_dnload;
  logic        adc_sub_ok;
  logic        resp_load;
  logic [7:0]  resp_cmd;
  logic [31:0] resp_val;
  logic [75:0] resp_frame;
  logic        user_wr;

  assign rx_match   = (rx_frame[COB_MSB:COB_LSB] == RX_COB) && !rx_frame[RTR_BIT];
  assign is_dnload  = (req_cmd == CMD_DNLOAD_4) || (req_cmd == CMD_DNLOAD_3) ||
                      (req_cmd == CMD_DNLOAD_2) || (req_cmd == CMD_DNLOAD_1);
  assign adc_sub_ok = (req_sub != 8'h00) && (req_sub <= N_ADC_SUB);

  // Next state, response selection and user register write strobe
  always_comb begin
    state_nxt = state;
    resp_load = 1'b0;
    resp_cmd  = CMD_ABORT;
    resp_val  = '0;
    user_wr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && rx_match) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        state_nxt = ST_SEND;
        resp_load = 1'b1;
        if (req_cmd == CMD_UPLOAD_REQ) begin
          case (req_idx)
            IDX_ADC: begin
              if (adc_sub_ok) begin
                state_nxt = ST_ADC_WAIT;
                resp_load = 1'b0;
              end else begin
                resp_val = ABORT_NO_SUB;
              end
            end
            IDX_DEV_TYPE: begin
              if (req_sub == 8'h00) begin
                resp_cmd = CMD_UPLOAD_RSP4;
                resp_val = DEV_TYPE;
              end else begin
                resp_val = ABORT_NO_SUB;
              end
            end
            IDX_USER_REG: begin
              if (req_sub == 8'h00) begin
                resp_cmd = CMD_UPLOAD_RSP4;
                resp_val = user_reg;
              end else begin
                resp_val = ABORT_NO_SUB;
              end
            end
            default: resp_val = ABORT_NO_OBJECT;
          endcase
        end else if (is_dnload) begin
          case (req_idx)
            IDX_USER_REG: begin
              if (req_sub == 8'h00) begin
                resp_cmd = CMD_DNLOAD_RSP;
                user_wr  = 1'b1;
              end else begin
                resp_val = ABORT_NO_SUB;
              end
            end
            IDX_ADC, IDX_DEV_TYPE: resp_val = ABORT_READ_ONLY;
            default:               resp_val = ABORT_NO_OBJECT;
          endcase
        end else begin
          resp_val = ABORT_BAD_CMD;
        end
      end
      ST_ADC_WAIT: begin
        // Ack takes priority over a timeout expiring in the same cycle
        if (adc_ack) begin
          state_nxt = ST_SEND;
          resp_load = 1'b1;
          resp_cmd  = CMD_UPLOAD_RSP2;
          resp_val  = {20'h0_0000, adc_data};
        end else if (tmo_cnt == ADC_TIMEOUT) begin
          state_nxt = ST_SEND;
          resp_load = 1'b1;
          resp_val  = ABORT_HW_ERROR;
        end
      end
      ST_SEND: begin
        if (tx_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sdo_frame_pack u_pack (
    .cob   (TX_COB),
    .cmd   (resp_cmd),
    .idx   (req_idx),
    .sub   (req_sub),
    .value (resp_val),
    .frame (resp_frame)
  );

  // State, request latch, timeout counter, response frame and user register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      req_cmd  <= '0;
      req_idx  <= '0;
      req_sub  <= '0;
      req_val  <= '0;
      tmo_cnt  <= '0;
      tx_frame <= '0;
      user_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && rx_valid) begin
        req_cmd <= rx_frame[CMD_MSB:CMD_LSB];
        req_idx <= {rx_frame[IDXH_MSB:IDXH_LSB], rx_frame[IDXL_MSB:IDXL_LSB]};
        req_sub <= rx_frame[SUB_MSB:SUB_LSB];
        req_val <= swap_bytes(rx_frame[DATA_MSB:DATA_LSB]);
      end
      if (state == ST_DECODE) begin
        tmo_cnt <= '0;
      end else if (state == ST_ADC_WAIT && tmo_cnt != '1) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (resp_load) tx_frame <= resp_frame;
      if (user_wr) user_reg <= req_val & dnload_mask(req_cmd);
    end
  end

  assign rx_ready = (state == ST_IDLE);
  assign tx_valid = (state == ST_SEND);
  assign busy     = (state != ST_IDLE);
  assign adc_req  = (state == ST_ADC_WAIT);
  assign adc_ch   = (state == ST_ADC_WAIT) ? req_sub[5:0] : '0;

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Scoreboard bench for mops_sdo_responder: expected frames are queued when a
// request is driven and compared when the responder hands a frame over.
module tb_mops_sdo_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [75:0] rx_frame;
  logic        rx_valid;
  logic        rx_ready;
  logic [75:0] tx_frame;
  logic        tx_valid;
  logic        tx_ready;
  logic        adc_req;
  logic [5:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic [31:0] user_reg;
  logic        busy;

  int checks  = 0;
  int errors  = 0;
  int tx_seen = 0;
  logic [75:0] exp_q[$];

  always #5 clk = ~clk;

  mops_sdo_responder #(
    .NODE_ID    (7'h01),
    .N_ADC      (35),
    .DEV_TYPE   (32'h0004_0191),
    .ADC_TIMEOUT(16'd100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_frame(rx_frame),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_frame(tx_frame),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .adc_req (adc_req),
    .adc_ch  (adc_ch),
    .adc_ack (adc_ack),
    .adc_data(adc_data),
    .user_reg(user_reg),
    .busy    (busy)
  );

  task automatic check_val(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [75:0] mk_req(input logic [10:0] cob, input logic rtr,
                                         input logic [7:0] cmd, input logic [15:0] idx,
                                         input logic [7:0] sub, input logic [31:0] bytes47);
    return {cob, rtr, cmd, idx[7:0], idx[15:8], sub, bytes47};
  endfunction

  function automatic logic [75:0] mk_rsp(input logic [7:0] cmd, input logic [15:0] idx,
                                         input logic [7:0] sub, input logic [31:0] bytes47);
    return {11'h581, 1'b0, cmd, idx[7:0], idx[15:8], sub, bytes47};
  endfunction

  // Each handshake is seen at the negedge before the accepting posedge
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      tx_seen++;
      if (exp_q.size() == 0) check_val("extra_tx", tx_frame, '0);
      else                   check_val("tx_frame", tx_frame, exp_q.pop_front());
    end
  end

  task automatic send_req(input logic [75:0] f);
    int n = 0;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_val("rx_ready_wait", 76'(rx_ready), 76'd1);
    rx_frame = f;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_val(tag, 76'(exp_q.size()), 76'd0);
  endtask

  task automatic wait_tx_valid(input string tag);
    int n = 0;
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 76'(tx_valid), 76'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [75:0] reqs[5];
    logic [75:0] rsps[5];
    logic [75:0] snap;
    int n;
    int bad_rdy;
    int bad_frm;
    int seen0;

    rst      = 1'b0;
    rx_frame = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    adc_ack  = 1'b0;
    adc_data = '0;
    repeat (3) @(negedge clk);
    check_val("reset_ctrl", 76'({rx_ready, tx_valid, adc_req, busy, adc_ch, user_reg}),
              76'({1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0}));
    check_val("reset_tx_frame", tx_frame, '0);
    rst = 1'b1;
    @(negedge clk);

    // ADC upload, channel 3, ack after 20 cycles
    exp_q.push_back(mk_rsp(8'h4B, 16'h2400, 8'h03, 32'hBC0A_0000));
    send_req(mk_req(11'h601, 1'b0, 8'h40, 16'h2400, 8'h03, 32'h0));
    n = 0;
    while (!adc_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("adc_req_up", 76'(adc_req), 76'd1);
    check_val("adc_ch", 76'(adc_ch), 76'd3);
    repeat (20) @(negedge clk);
    adc_data = 12'hABC;
    adc_ack  = 1'b1;
    @(negedge clk);
    adc_ack  = 1'b0;
    check_val("adc_tx_latency", 76'(tx_valid), 76'd1);
    check_val("adc_req_drop", 76'(adc_req), 76'd0);
    wait_drain("drain_adc", 50);

    // Download 4 bytes to user register, with latency checks
    exp_q.push_back(mk_rsp(8'h60, 16'h2200, 8'h00, 32'h0));
    send_req(mk_req(11'h601, 1'b0, 8'h23, 16'h2200, 8'h00, 32'h7856_3412));
    check_val("dl_n1_tx_valid", 76'(tx_valid), 76'd0);
    check_val("dl_n1_rx_ready", 76'(rx_ready), 76'd0);
    @(negedge clk);
    check_val("dl_n2_tx_valid", 76'(tx_valid), 76'd1);
    @(negedge clk);
    check_val("dl_n3_rx_ready", 76'(rx_ready), 76'd1);
    wait_drain("drain_dl", 50);
    check_val("user_reg_4b", 76'(user_reg), 76'h1234_5678);

    exp_q.push_back(mk_rsp(8'h43, 16'h2200, 8'h00, 32'h7856_3412));
    send_req(mk_req(11'h601, 1'b0, 8'h40, 16'h2200, 8'h00, 32'h0));
    wait_drain("drain_ul_user", 50);

    // One-byte download clears the upper bytes
    exp_q.push_back(mk_rsp(8'h60, 16'h2200, 8'h00, 32'h0));
    send_req(mk_req(11'h601, 1'b0, 8'h2F, 16'h2200, 8'h00, 32'hAABB_CCDD));
    wait_drain("drain_dl1", 50);
    check_val("user_reg_1b", 76'(user_reg), 76'h0000_00AA);

    // Abort and device-type table
    reqs[0] = mk_req(11'h601, 1'b0, 8'h40, 16'h2400, 8'h30, 32'h0);
    rsps[0] = mk_rsp(8'h80, 16'h2400, 8'h30, 32'h1100_0906);
    reqs[1] = mk_req(11'h601, 1'b0, 8'h55, 16'h2200, 8'h00, 32'h0);
    rsps[1] = mk_rsp(8'h80, 16'h2200, 8'h00, 32'h0100_0405);
    reqs[2] = mk_req(11'h601, 1'b0, 8'h23, 16'h1000, 8'h00, 32'h1111_1111);
    rsps[2] = mk_rsp(8'h80, 16'h1000, 8'h00, 32'h0200_0106);
    reqs[3] = mk_req(11'h601, 1'b0, 8'h40, 16'h3000, 8'h00, 32'h0);
    rsps[3] = mk_rsp(8'h80, 16'h3000, 8'h00, 32'h0000_0206);
    reqs[4] = mk_req(11'h601, 1'b0, 8'h40, 16'h1000, 8'h00, 32'h0);
    rsps[4] = mk_rsp(8'h43, 16'h1000, 8'h00, 32'h9101_0400);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(rsps[i]);
      send_req(reqs[i]);
      wait_drain("drain_table", 50);
    end
    check_val("user_reg_after_ro", 76'(user_reg), 76'h0000_00AA);

    // ADC timeout: abort 101 cycles after entering ADC_WAIT
    exp_q.push_back(mk_rsp(8'h80, 16'h2400, 8'h05, 32'h0000_0008));
    send_req(mk_req(11'h601, 1'b0, 8'h40, 16'h2400, 8'h05, 32'h0));
    @(negedge clk);
    n = 1;
    check_val("tmo_adc_req", 76'({adc_req, adc_ch}), 76'({1'b1, 6'd5}));
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("tmo_latency", 76'(n), 76'd102);
    wait_drain("drain_tmo", 50);
    seen0 = tx_seen;
    adc_data = 12'h123;
    adc_ack  = 1'b1;
    @(negedge clk);
    adc_ack  = 1'b0;
    repeat (20) @(negedge clk);
    check_val("late_ack_no_tx", 76'(tx_seen), 76'(seen0));
    check_val("late_ack_idle", 76'(busy), 76'd0);

    // Frames for another node or with RTR set are dropped
    seen0   = tx_seen;
    bad_rdy = 0;
    send_req(mk_req(11'h602, 1'b0, 8'h40, 16'h1000, 8'h00, 32'h0));
    repeat (200) begin
      if (!rx_ready || tx_valid) bad_rdy++;
      @(negedge clk);
    end
    send_req(mk_req(11'h601, 1'b1, 8'h40, 16'h1000, 8'h00, 32'h0));
    repeat (200) begin
      if (!rx_ready || tx_valid) bad_rdy++;
      @(negedge clk);
    end
    check_val("drop_ready_cycles", 76'(bad_rdy), 76'd0);
    check_val("drop_no_tx", 76'(tx_seen), 76'(seen0));

    // Back-pressure: frame stable, no new request accepted
    tx_ready = 1'b0;
    exp_q.push_back(mk_rsp(8'h43, 16'h1000, 8'h00, 32'h9101_0400));
    send_req(mk_req(11'h601, 1'b0, 8'h40, 16'h1000, 8'h00, 32'h0));
    wait_tx_valid("hold_tx_valid");
    snap    = tx_frame;
    bad_frm = 0;
    bad_rdy = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_frame !== snap || !tx_valid) bad_frm++;
      if (rx_ready) bad_rdy++;
    end
    check_val("hold_frame_stable", 76'(bad_frm), 76'd0);
    check_val("hold_rx_ready_low", 76'(bad_rdy), 76'd0);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain("drain_hold", 50);

    // Reset while a response is pending
    tx_ready = 1'b0;
    send_req(mk_req(11'h601, 1'b0, 8'h40, 16'h2200, 8'h00, 32'h0));
    wait_tx_valid("rst_pre_tx_valid");
    rst = 1'b0;
    #1;
    check_val("rst_mid_send", 76'({tx_valid, busy, rx_ready, user_reg}),
              76'({1'b0, 1'b0, 1'b1, 32'd0}));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk_rsp(8'h43, 16'h2200, 8'h00, 32'h0));
    send_req(mk_req(11'h601, 1'b0, 8'h40, 16'h2200, 8'h00, 32'h0));
    wait_drain("drain_after_rst", 50);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
